// File: rtl/s27_bist_ctrl.sv
// BIST controller for the s27 core: LFSR pattern source on a..d, 16-bit MISR on f.
// Optional flush phase and sig export are enabled by defining S27_BIST_FLUSH_EN.
module s27_bist_ctrl #(
    parameter int           NUM_PATTERNS = 64,
    parameter logic [7:0]   LFSR_SEED    = 8'h01,
    parameter logic [15:0]  GOLDEN_SIG   = 16'h0000
`ifdef S27_BIST_FLUSH_EN
    ,
    parameter int           FLUSH_CYCLES = 2
`endif
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic        f,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        busy,
    output logic        done,
    output logic        pass
`ifdef S27_BIST_FLUSH_EN
    ,
    output logic [15:0] sig
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH,
        S_RUN,
        S_TAIL,
        S_DONE
    } state_e;

    localparam logic [7:0] RUN_LAST   = 8'(NUM_PATTERNS - 1);
`ifdef S27_BIST_FLUSH_EN
    localparam logic [7:0] FLUSH_LAST = 8'(FLUSH_CYCLES - 1);
    // Forces s27 state to a known value in one cycle, whatever it powered up in.
    localparam logic [3:0] FLUSH_PAT  = 4'b1110;
`endif

    state_e      state_q, state_d;
    logic [7:0]  lfsr_q, lfsr_d;
    logic [15:0] misr_q, misr_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  pat_q, pat_d;
    logic [7:0]  lfsr_nxt;
    logic        capture;

    assign lfsr_nxt = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            lfsr_q  <= LFSR_SEED;
            misr_q  <= 16'h0000;
            cnt_q   <= 8'd0;
            pat_q   <= 4'b0000;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            misr_q  <= misr_d;
            cnt_q   <= cnt_d;
            pat_q   <= pat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        misr_d  = misr_q;
        cnt_d   = cnt_q;
        pat_d   = pat_q;
        capture = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    lfsr_d = LFSR_SEED;
                    misr_d = 16'h0000;
                    cnt_d  = 8'd0;
`ifdef S27_BIST_FLUSH_EN
                    state_d = S_FLUSH;
                    pat_d   = FLUSH_PAT;
`else
                    state_d = S_RUN;
                    pat_d   = LFSR_SEED[3:0];
`endif
                end
            end
`ifdef S27_BIST_FLUSH_EN
            S_FLUSH: begin
                if (cnt_q == FLUSH_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = 8'd0;
                    pat_d   = lfsr_q[3:0];
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
`endif
            S_RUN: begin
                lfsr_d = lfsr_nxt;
                cnt_d  = cnt_q + 8'd1;
                // The first RUN cycle has no response of its own yet to capture.
                capture = (cnt_q != 8'd0);
                if (cnt_q == RUN_LAST) begin
                    state_d = S_TAIL;
                end else begin
                    pat_d = lfsr_nxt[3:0];
                end
            end
            S_TAIL: begin
                capture = 1'b1;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        if (capture) begin
            misr_d = {misr_q[14:0], 1'b0} ^ (misr_q[15] ? 16'h1021 : 16'h0000) ^ {15'b0, f};
        end
    end

    assign {a, b, c, d} = pat_q;
    assign busy = (state_q == S_FLUSH) || (state_q == S_RUN) || (state_q == S_TAIL);
    assign done = (state_q == S_DONE);
    assign pass = done && (misr_q == GOLDEN_SIG);
`ifdef S27_BIST_FLUSH_EN
    assign sig  = misr_q;
`endif

endmodule

// File: doc/s27_bist_ctrl.md
# s27_bist_ctrl

Built-in self-test controller wrapped around the s27 sequential benchmark netlist. It drives the DUT primary inputs (a, b, c, d) directly with LFSR-generated patterns and compacts the DUT output f into a 16-bit MISR. When the run ends it compares the signature against a golden value. It is the direct upstream source and downstream sink of the s27 core: it owns all four DUT inputs and consumes f.

## Interface
- NUM_PATTERNS, 64: number of patterns applied per run, range 1..255.
- LFSR_SEED, 8'h01: LFSR value loaded at reset and at each run start; must be nonzero.
- GOLDEN_SIG, 16'h0000: expected final MISR signature.
- FLUSH_CYCLES, 2: number of flush cycles. Used only when S27_BIST_FLUSH_EN is defined.

- clock  in  1  single clock; all controller flops are posedge. The DUT state flops update on the intervening negedge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  run request; sampled at posedge in IDLE or DONE.
- f  in  1  DUT output, combinational from the DUT inputs and DUT state.
- a, b, c, d  out  1 each  registered DUT inputs; {a,b,c,d} = lfsr[3:0] during RUN.
- busy  out  1  high in FLUSH, RUN and TAIL.
- done  out  1  high in DONE.
- pass  out  1  (misr == GOLDEN_SIG); valid only while done is high, 0 otherwise.
- sig  out  16  current MISR value. Present only when S27_BIST_FLUSH_EN is defined (see Configuration).

## Operation
- States: IDLE, FLUSH, RUN, TAIL, DONE.
- Reset: state IDLE, lfsr = LFSR_SEED, misr = 0, cnt = 0; a = b = c = d = 0; busy = done = pass = 0.
- IDLE or DONE with start = 1:
  - lfsr <= LFSR_SEED, misr <= 0, cnt <= 0.
  - Next state is FLUSH if the macro is defined, otherwise RUN.
- FLUSH: {a,b,c,d} = 4'b1110 for FLUSH_CYCLES cycles, then RUN.
  - One cycle of this pattern forces DUT state to lo0 = 1, lo1 = 0, lo2 = 0, independent of prior state.
- RUN: {a,b,c,d} = lfsr[3:0] each cycle.
  - lfsr advances every cycle: lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
  - cnt increments every cycle.
  - After NUM_PATTERNS cycles, go to TAIL.
- TAIL: one cycle; a..d hold the last pattern; captures the final response. Then DONE.
- DONE: a..d hold; done = 1; pass is valid. Remains in DONE until start.
- start in FLUSH, RUN or TAIL is ignored.
- MISR update, performed at each capture:
  - misr <= {misr[14:0],1'b0} ^ (misr[15] ? 16'h1021 : 16'h0) ^ {15'b0, f}.
- Captures occur at the posedges ending RUN cycles 2..NUM_PATTERNS and the TAIL cycle: exactly NUM_PATTERNS captures, none during FLUSH.
- cnt is 8 bits wide; no wrap occurs within the allowed range.

## Timing
- Pattern k is presented on a..d for one clock. Its response f is captured at the next posedge, so capture latency is 1 cycle.
- busy and a..d change at the posedge that samples start.
- done rises (FLUSH ? FLUSH_CYCLES : 0) + NUM_PATTERNS + 1 cycles after the posedge that sampled start.
- pass is registered together with done.
- reset_n low at any time, including mid-RUN: all outputs clear immediately (asynchronously) and the state returns to IDLE.
  - reset_n release requires no start; the block stays in IDLE until start.
- Simultaneous start and reset_n low: reset wins.

## Configuration
- S27_BIST_FLUSH_EN defined:
  - FLUSH state is present.
  - The signature is deterministic regardless of DUT power-up state.
  - The sig port is exported for golden-value extraction.
- S27_BIST_FLUSH_EN not defined:
  - FLUSH is skipped and start goes directly to RUN.
  - The signature depends on DUT initial state.
  - The sig port is absent.

## Test plan
- Reset: reset_n = 0 mid-RUN -> a..d = 0, busy = done = pass = 0 asynchronously; after release, IDLE with lfsr = 8'h01.
- Pattern order: NUM_PATTERNS = 4, no flush, start pulse -> a..d sequence 0001, 0010, 0100, 1000; done high 5 cycles after start is sampled.
- Flush: macro defined, FLUSH_CYCLES = 2 -> {a,b,c,d} = 1110 for 2 cycles before 0001; done at +7 cycles with NUM_PATTERNS = 4.
- Compaction: stub f = 0 with GOLDEN_SIG = 0 -> sig = 16'h0000, pass = 1. Stub f = 1 with NUM_PATTERNS = 2 -> sig = 16'h0003, pass = 0.
- Start handling: start pulses during RUN have no effect. start in DONE -> lfsr reloads 8'h01, misr clears, a new run begins, done drops.
- Real s27 with flush, NUM_PATTERNS = 64: a run started from DUT initial state all-0s and a run started from all-1s produce identical sig.
